// File: rtl/image_loader.sv
// image_loader: turns a valid/ready stream of 16-bit image words into packed
// {send_img, bit_offset[14:0], data[15:0]} commands for the image buffer stage,
// and appends one commit command (send_img=1) after the last word of each frame.
// Optional feature macro: IMAGE_LOADER_LAST_CHECK_EN enables s_last framing checks
// (err_early / err_missing); without it s_last is ignored and the errors stay 0.
module image_loader #(
  parameter  int FRAME_BITS = 2500,
  localparam int NWORDS     = (FRAME_BITS + 15) / 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  input  logic        s_last,
  output logic [31:0] addr_din,
  output logic        frame_done,
  output logic [7:0]  word_idx,
  output logic        err_early,
  output logic        err_missing
);

  typedef enum logic {
    LOAD   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NWORDS - 1);

  state_t      r_state;
  logic [7:0]  r_word_idx;
  logic [31:0] r_addr_din;
  logic        r_frame_done;
  logic        r_err_early;
  logic        r_err_missing;

  logic        w_fire;
  logic        w_is_last;
  logic [14:0] w_offset;
  logic        w_early;
  logic        w_missing;

  // A word is taken only while loading; the commit cycle is the single bubble.
  assign w_fire    = s_valid && (r_state == LOAD);
  assign w_is_last = (r_word_idx == LAST_IDX);
  // Bit offset of the current word: word index times 16, widened to 15 bits.
  assign w_offset  = {3'b000, r_word_idx, 4'b0000};

`ifdef IMAGE_LOADER_LAST_CHECK_EN
  assign w_early   = s_last && !w_is_last;
  assign w_missing = !s_last && w_is_last;
`else
  logic w_unused_last;
  assign w_unused_last = s_last;
  assign w_early       = 1'b0;
  assign w_missing     = 1'b0;
`endif

  // Frame FSM: stream words in LOAD, then spend one cycle in COMMIT raising send_img.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= LOAD;
      r_word_idx    <= 8'd0;
      r_addr_din    <= 32'd0;
      r_frame_done  <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_fire) begin
            r_addr_din    <= {1'b0, w_offset, s_data};
            r_err_early   <= w_early;
            r_err_missing <= w_missing;
            if (w_early) begin
              // Frame ended too soon: drop it and restart at word 0, no commit.
              r_word_idx <= 8'd0;
            end else if (w_is_last) begin
              r_word_idx <= 8'd0;
              r_state    <= COMMIT;
            end else begin
              r_word_idx <= r_word_idx + 8'd1;
            end
          end else begin
            // Hold offset/data so the downstream write is a harmless repeat.
            r_addr_din[31] <= 1'b0;
          end
        end
        COMMIT: begin
          // Re-issue the final word with send_img set so the buffer publishes.
          r_addr_din[31] <= 1'b1;
          r_frame_done   <= 1'b1;
          r_state        <= LOAD;
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign s_ready     = (r_state == LOAD);
  assign addr_din    = r_addr_din;
  assign frame_done  = r_frame_done;
  assign word_idx    = r_word_idx;
  assign err_early   = r_err_early;
  assign err_missing = r_err_missing;

endmodule
